// File: rtl/spi_xfer_sequencer_if.sv
// Host TX/RX byte handshake plus the register bus to the SPI master controller.
// slave = sequencer side, master = host/controller side.
interface spi_xfer_sequencer_if;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        clr_cnt;
  logic        busy;
  logic [7:0]  ntx;
  logic        err;
  logic [31:0] ctrl_out;
  logic [31:0] data_out;
  logic [31:0] ctrl_in;
  logic        ctrl_we;
  logic [31:0] data_in;
  logic        data_we;

  modport slave (
    input  tx_valid, tx_data, rx_ready, clr_cnt, ctrl_in, ctrl_we, data_in, data_we,
    output tx_ready, rx_valid, rx_data, busy, ntx, err, ctrl_out, data_out
  );

  modport master (
    output tx_valid, tx_data, rx_ready, clr_cnt, ctrl_in, ctrl_we, data_in, data_we,
    input  tx_ready, rx_valid, rx_data, busy, ntx, err, ctrl_out, data_out
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Host-side sequencer for the SPI master controller: TX/RX byte FIFOs, control/data registers.
// Optional WAIT/CLR watchdog is built in when SPI_SEQ_TIMEOUT_EN is defined.
module spi_xfer_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  spi_xfer_sequencer_if.slave bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_CLR     = 3'd5,
    S_CLR_END = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   ctrl_q, ctrl_d, data_q, data_d;
  logic [31:0]   seq_ctrl_s, seq_data_s;
  logic          err_q, err_d;
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [CW-1:0] tx_cnt_q, rx_cnt_q;
  logic          tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic          tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic          timeout_s;

  assign tx_full_s  = (tx_cnt_q == CNT_FULL);
  assign tx_empty_s = (tx_cnt_q == '0);
  assign rx_full_s  = (rx_cnt_q == CNT_FULL);
  assign rx_empty_s = (rx_cnt_q == '0);
  assign tx_push_s  = bus.tx_valid && !tx_full_s;
  assign rx_pop_s   = bus.rx_ready && !rx_empty_s;

  assign bus.tx_ready = !tx_full_s;
  assign bus.rx_valid = !rx_empty_s;
  assign bus.rx_data  = rx_mem_q[rx_rd_q];
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.ntx      = ctrl_q[15:8];
  assign bus.err      = err_q;
  assign bus.ctrl_out = ctrl_q;
  assign bus.data_out = data_q;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          wd_run_s;

  assign wd_run_s  = (state_q == S_WAIT) || (state_q == S_CLR);
  assign timeout_s = wd_run_s && (wd_q == WW'(TIMEOUT_CYCLES - 1));

  // Watchdog restarts from zero each time WAIT or CLR is entered
  always_comb begin
    wd_d = '0;
    if (wd_run_s) begin
      wd_d = wd_q + WW'(1);
    end else begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = |32'(TIMEOUT_CYCLES);
  assign timeout_s        = 1'b0;
`endif

  // FIFO storage is not reset; occupancy counts define validity
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_q[tx_wr_q] <= bus.tx_data;
    if (rx_push_s) rx_mem_q[rx_wr_q] <= data_q[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_push_s) tx_wr_q <= tx_wr_q + PTR_ONE;
      if (tx_pop_s)  tx_rd_q <= tx_rd_q + PTR_ONE;
      if (rx_push_s) rx_wr_q <= rx_wr_q + PTR_ONE;
      if (rx_pop_s)  rx_rd_q <= rx_rd_q + PTR_ONE;
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_cnt_q <= tx_cnt_q + CNT_ONE;
        2'b01:   tx_cnt_q <= tx_cnt_q - CNT_ONE;
        default: tx_cnt_q <= tx_cnt_q;
      endcase
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_cnt_q <= rx_cnt_q + CNT_ONE;
        2'b01:   rx_cnt_q <= rx_cnt_q - CNT_ONE;
        default: rx_cnt_q <= rx_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ctrl_q  <= 32'h0000_0000;
      data_q  <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    seq_ctrl_s = ctrl_q;
    seq_data_s = data_q;
    err_d      = err_q;
    tx_pop_s   = 1'b0;
    rx_push_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.clr_cnt) begin
          seq_ctrl_s[1:0] = 2'b10;
          state_d         = S_CLR;
        end else if (!tx_empty_s && !rx_full_s) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        tx_pop_s   = 1'b1;
        seq_data_s = {24'h00_0000, tx_mem_q[tx_rd_q]};
        state_d    = S_START;
      end
      S_START: begin
        seq_ctrl_s[1:0] = 2'b01;
        state_d         = S_WAIT;
      end
      S_WAIT: begin
        if (bus.data_we) begin
          state_d = S_CAPTURE;
        end else if (timeout_s) begin
          err_d           = 1'b1;
          seq_ctrl_s[1:0] = 2'b00;
          state_d         = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_CAPTURE: begin
        rx_push_s = 1'b1;
        state_d   = S_IDLE;
      end
      S_CLR: begin
        if (bus.ctrl_we) begin
          state_d = S_CLR_END;
        end else if (timeout_s) begin
          err_d           = 1'b1;
          seq_ctrl_s[1:0] = 2'b00;
          state_d         = S_IDLE;
        end else begin
          state_d = S_CLR;
        end
      end
      S_CLR_END: begin
        seq_ctrl_s[1] = 1'b0;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Controller write-back always wins over the sequencer's own update
    ctrl_d = bus.ctrl_we ? bus.ctrl_in : seq_ctrl_s;
    data_d = bus.data_we ? bus.data_in : seq_data_s;
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Randomized scoreboard bench for spi_xfer_sequencer with a transaction-level controller model.
// Define SPI_SEQ_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_spi_xfer_sequencer;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 4096;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_xfer_sequencer_if bus ();

  spi_xfer_sequencer #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         model_cnt = 0;
  logic [7:0] exp_tx [$];
  logic [7:0] exp_rx [$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard monitor: every byte the host pops must match the next expected RX byte
  always @(negedge clk) begin
    if (!rst && bus.rx_valid && bus.rx_ready) begin
      if (exp_rx.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got 0x%0h expected no byte", bus.rx_data);
      end else begin
        chk("rx_data", 32'(bus.rx_data), 32'(exp_rx.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    int t = 0;
    while (!bus.tx_ready && t < 50) begin
      tick();
      t++;
    end
    chk("tx_ready_wait", 32'(bus.tx_ready), 32'd1);
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    tick();
    bus.tx_valid = 1'b0;
    exp_tx.push_back(b);
  endtask

  task automatic wait_send(output bit ok);
    int t = 0;
    while (bus.ctrl_out[0] !== 1'b1 && t < 40) begin
      tick();
      t++;
    end
    ok = (bus.ctrl_out[0] === 1'b1);
    chk("send_seen", 32'(ok), 32'd1);
  endtask

  // Controller model: one transaction = return rxb and bump the count
  task automatic serve(input logic [7:0] rxb, input bit pulse_clr);
    bit          ok;
    logic [7:0]  eb;
    logic [31:0] r;
    int          d;
    wait_send(ok);
    if (ok) begin
      eb = (exp_tx.size() != 0) ? exp_tx.pop_front() : 8'h00;
      chk("data_out_tx", bus.data_out, {24'd0, eb});
      chk("busy_wait", 32'(bus.busy), 32'd1);
      if (pulse_clr) begin
        bus.clr_cnt = 1'b1;
        tick();
        bus.clr_cnt = 1'b0;
      end
      d = $urandom_range(0, 2);
      for (int i = 0; i < d; i++) tick();
      chk("send_hold", 32'(bus.ctrl_out[1:0]), 32'd1);
      model_cnt   = (model_cnt + 1) % 256;
      r           = $urandom();
      bus.ctrl_in = {16'd0, 8'(model_cnt), 8'd0};
      bus.ctrl_we = 1'b1;
      bus.data_in = {r[31:8], rxb};
      bus.data_we = 1'b1;
      exp_rx.push_back(rxb);
      tick();
      bus.ctrl_we = 1'b0;
      bus.data_we = 1'b0;
      chk("ntx", 32'(bus.ntx), 32'(model_cnt));
    end
  endtask

  task automatic preload_cnt(input int c);
    bus.ctrl_in = {16'd0, 8'(c), 8'd0};
    bus.ctrl_we = 1'b1;
    tick();
    bus.ctrl_we = 1'b0;
    model_cnt   = c;
    chk("ntx_preload", 32'(bus.ntx), 32'(c));
  endtask

  task automatic drain();
    int t = 0;
    bus.rx_ready = 1'b1;
    while (bus.rx_valid && t < 40) begin
      tick();
      t++;
    end
    chk("rx_drained", 32'(bus.rx_valid), 32'd0);
  endtask

  initial begin
    bit ok;
    int k;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.rx_ready = 1'b0;
    bus.clr_cnt  = 1'b0;
    bus.ctrl_in  = 32'd0;
    bus.ctrl_we  = 1'b0;
    bus.data_in  = 32'd0;
    bus.data_we  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ntx", 32'(bus.ntx), 32'd0);
    chk("rst_ctrl", bus.ctrl_out, 32'd0);
    chk("rst_data", bus.data_out, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);

    // Single byte with RX latency check
    push_tx(8'hA5);
    serve(8'h3C, 1'b0);
    chk("ntx_single", 32'(bus.ntx), 32'd1);
    chk("rx_lat_1", 32'(bus.rx_valid), 32'd0);
    tick();
    chk("rx_lat_2", 32'(bus.rx_valid), 32'd1);
    chk("rx_head", 32'(bus.rx_data), 32'h3C);
    drain();

    // Random traffic
    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(1, 3);
      for (int i = 0; i < k; i++) push_tx(8'($urandom_range(0, 255)));
      for (int i = 0; i < k; i++) serve(8'($urandom_range(0, 255)), 1'b0);
    end
    drain();

    // TX FIFO full with the controller stalled: 1 byte in flight + 8 queued
    for (int i = 0; i < 9; i++) push_tx(8'($urandom_range(0, 255)));
    chk("tx_full", 32'(bus.tx_ready), 32'd0);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hEE;
    tick();
    bus.tx_valid = 1'b0;
    for (int i = 0; i < 9; i++) serve(8'($urandom_range(0, 255)), 1'b0);
    drain();
    for (int i = 0; i < 6; i++) tick();
    chk("no_stray_busy", 32'(bus.busy), 32'd0);
    chk("no_stray_send", 32'(bus.ctrl_out[0]), 32'd0);

    // RX backpressure: 9th byte held until one pop
    bus.rx_ready = 1'b0;
    for (int i = 0; i < 9; i++) push_tx(8'($urandom_range(0, 255)));
    for (int i = 0; i < 8; i++) serve(8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("bp_busy", 32'(bus.busy), 32'd0);
    chk("bp_send", 32'(bus.ctrl_out[0]), 32'd0);
    chk("bp_rx_valid", 32'(bus.rx_valid), 32'd1);
    chk("bp_tx_ready", 32'(bus.tx_ready), 32'd1);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    serve(8'($urandom_range(0, 255)), 1'b0);
    drain();

    // Clear count takes priority over a queued byte
    preload_cnt(5);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h5A;
    tick();
    bus.tx_valid = 1'b0;
    exp_tx.push_back(8'h5A);
    bus.clr_cnt = 1'b1;
    tick();
    bus.clr_cnt = 1'b0;
    chk("clr_bits", 32'(bus.ctrl_out[1:0]), 32'd2);
    chk("clr_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("clr_hold", 32'(bus.ctrl_out[1:0]), 32'd2);
    bus.ctrl_in = 32'h0000_0002;
    bus.ctrl_we = 1'b1;
    tick();
    bus.ctrl_we = 1'b0;
    model_cnt   = 0;
    chk("clr_ntx", 32'(bus.ntx), 32'd0);
    tick();
    chk("clr_done", 32'(bus.ctrl_out[1:0]), 32'd0);
    serve(8'h77, 1'b0);
    drain();

    // clr_cnt outside IDLE is dropped
    push_tx(8'h11);
    serve(8'h22, 1'b1);
    drain();
    for (int i = 0; i < 4; i++) tick();
    chk("clr_dropped_bit", 32'(bus.ctrl_out[1]), 32'd0);
    chk("clr_dropped_busy", 32'(bus.busy), 32'd0);

    // Counter wrap 255 -> 0
    preload_cnt(255);
    push_tx(8'h99);
    serve(8'h66, 1'b0);
    chk("ntx_wrap", 32'(bus.ntx), 32'd0);
    drain();

`ifdef SPI_SEQ_TIMEOUT_EN
    // Watchdog: no data_we while waiting
    push_tx(8'h42);
    wait_send(ok);
    if (exp_tx.size() != 0) void'(exp_tx.pop_front());
    for (int i = 0; i < 15; i++) tick();
    chk("to_err_early", 32'(bus.err), 32'd0);
    chk("to_busy_early", 32'(bus.busy), 32'd1);
    tick();
    chk("to_err", 32'(bus.err), 32'd1);
    chk("to_busy", 32'(bus.busy), 32'd0);
    chk("to_send", 32'(bus.ctrl_out[1:0]), 32'd0);
    chk("to_rx_empty", 32'(bus.rx_valid), 32'd0);
`else
    chk("err_tied_low", 32'(bus.err), 32'd0);
`endif

    // Reset in the middle of WAIT with another byte queued
    push_tx(8'hC3);
    push_tx(8'h3C);
    wait_send(ok);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_tx.delete();
    exp_rx.delete();
    model_cnt = 0;
    chk("mrst_ctrl", bus.ctrl_out, 32'd0);
    chk("mrst_data", bus.data_out, 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("mrst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("mrst_ntx", 32'(bus.ntx), 32'd0);
    chk("mrst_err", 32'(bus.err), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("mrst_idle", 32'(bus.busy), 32'd0);

    chk("exp_tx_empty", 32'(exp_tx.size()), 32'd0);
    chk("exp_rx_empty", 32'(exp_rx.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
